// File: rtl/reduction_pkg.sv
// Shared constants and elaboration-time helpers for the windowed modular reduction pipeline.
package reduction_pkg;

    localparam int unsigned DEF_W_Q     = 30;
    localparam int unsigned DEF_NUM_MOD = 6;

    // Entry i occupies bits [i*W_Q +: W_Q]; q0 is the least significant word.
    localparam logic [DEF_NUM_MOD*DEF_W_Q-1:0] DEFAULT_MODULI = {
        30'd1073479681, 30'd1072496641, 30'd1071513601,
        30'd1070727169, 30'd1069219841, 30'd1068564481
    };

    // (v * 2^w_q) mod q by repeated doubling with a conditional subtract.
    function automatic logic [63:0] table_entry(input logic [63:0] q, input logic [63:0] v,
                                                input int unsigned w_q);
        logic [64:0] r;
        r = {1'b0, v % q};
        for (int unsigned i = 0; i < w_q; i++) begin
            r = r << 1;
            if (r >= {1'b0, q}) r = r - {1'b0, q};
        end
        return r[63:0];
    endfunction

    function automatic int unsigned calc_steps(input int unsigned w_in, input int unsigned w_q,
                                               input int unsigned window);
        if (w_in <= w_q) return 0;
        return (w_in - w_q + window - 2) / (window - 1);
    endfunction

    function automatic int unsigned calc_latency(input int unsigned steps,
                                                 input int unsigned reg_every);
        return (steps + reg_every - 1) / reg_every + 1;
    endfunction

endpackage

// File: rtl/window_reduction_table.sv
// Per-modulus ROMs of (v * 2^W_Q) mod q, one word selected by the modulus index.
module window_reduction_table
    import reduction_pkg::*;
#(
    parameter int unsigned W_Q     = 30,
    parameter int unsigned WINDOW  = 6,
    parameter int unsigned NUM_MOD = 6,
    parameter int unsigned IDX_W   = 3,
    parameter logic [NUM_MOD*W_Q-1:0] MODULI = DEFAULT_MODULI
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic [WINDOW-1:0] v,
    output logic [W_Q-1:0]    entry_c
);

    localparam int unsigned DEPTH = 1 << WINDOW;

    logic [W_Q-1:0] rom [NUM_MOD][DEPTH];

    for (genvar m = 0; m < NUM_MOD; m++) begin : g_mod
        for (genvar e = 0; e < DEPTH; e++) begin : g_ent
            localparam logic [W_Q-1:0] ENT =
                W_Q'(table_entry(64'(MODULI[m*W_Q +: W_Q]), 64'(e), W_Q));
            assign rom[m][e] = ENT;
        end
    end

    // Illegal indices read as zero; the top flags them separately.
    always_comb begin
        entry_c = '0;
        for (int unsigned m = 0; m < NUM_MOD; m++) begin
            if (idx == IDX_W'(m)) entry_c = rom[m][v];
        end
    end

endmodule

// File: rtl/windowed_reduction_pipe.sv
// Pipelined x mod q over a run-time selectable modulus, folding WINDOW bits per table step.
module windowed_reduction_pipe
    import reduction_pkg::*;
#(
    parameter int unsigned W_IN      = 60,
    parameter int unsigned W_Q       = 30,
    parameter int unsigned WINDOW    = 6,
    parameter int unsigned NUM_MOD   = 6,
    parameter logic [NUM_MOD*W_Q-1:0] MODULI = DEFAULT_MODULI,
    parameter int unsigned REG_EVERY = 2,
    parameter int unsigned W_TAG     = 8
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [W_IN-1:0]                                      in_data,
    input  logic [((NUM_MOD > 1) ? $clog2(NUM_MOD) : 1)-1:0]     in_mod_idx,
    input  logic [W_TAG-1:0]                                     in_tag,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [W_Q-1:0]                                       out_data,
    output logic [W_TAG-1:0]                                     out_tag,
    output logic                                                 out_err
);

    localparam int unsigned IDX_W = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1;
    localparam int unsigned STEPS = calc_steps(W_IN, W_Q, WINDOW);
    localparam int unsigned W_BUS = (W_IN > W_Q) ? W_IN : W_Q + 1;
    localparam int unsigned W_R   = W_Q + 1;

    logic advance;

    // Combinational out_ready -> in_ready path: one global stall for every stage.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    logic [W_BUS-1:0] val_a [STEPS+1];
    logic             vld_a [STEPS+1];
    logic [IDX_W-1:0] idx_a [STEPS+1];
    logic [W_TAG-1:0] tag_a [STEPS+1];

    assign val_a[0] = W_BUS'(in_data);
    assign vld_a[0] = in_valid;
    assign idx_a[0] = in_mod_idx;
    assign tag_a[0] = in_tag;

    for (genvar k = 0; k < STEPS; k++) begin : g_step
        localparam int unsigned W_CUR  = W_IN - k * (WINDOW - 1);
        localparam bit          IS_REG = (((k + 1) % REG_EVERY) == 0) || (k == STEPS - 1);

        logic [WINDOW-1:0] v;
        logic [W_Q-1:0]    t;
        logic [W_BUS-1:0]  val_c;

        window_reduction_table #(
            .W_Q(W_Q), .WINDOW(WINDOW), .NUM_MOD(NUM_MOD), .IDX_W(IDX_W), .MODULI(MODULI)
        ) u_table (
            .idx(idx_a[k]), .v(v), .entry_c(t)
        );

        if (k < STEPS - 1) begin : g_win
            // Top WINDOW bits are replaced by their residue scaled back into position.
            localparam int unsigned      SH       = W_CUR - WINDOW - W_Q;
            localparam logic [W_BUS-1:0] LOW_MASK = (W_BUS'(1) << (W_CUR - WINDOW)) - W_BUS'(1);
            assign v     = val_a[k][W_CUR-1 -: WINDOW];
            assign val_c = (val_a[k] & LOW_MASK) + (W_BUS'(t) << SH);
        end else begin : g_fin
            // Fewer than WINDOW bits remain above W_Q; result is below 2^W_Q + q.
            localparam logic [W_BUS-1:0] LOW_MASK = (W_BUS'(1) << W_Q) - W_BUS'(1);
            assign v     = WINDOW'(val_a[k] >> W_Q);
            assign val_c = (val_a[k] & LOW_MASK) + W_BUS'(t);
        end

        if (IS_REG) begin : g_reg
            logic             vld_q;
            logic [W_BUS-1:0] val_q;
            logic [IDX_W-1:0] idx_q;
            logic [W_TAG-1:0] tag_q;

            always_ff @(posedge clk) begin
                if (!rst_n)       vld_q <= 1'b0;
                else if (advance) vld_q <= vld_a[k];
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    val_q <= val_c;
                    idx_q <= idx_a[k];
                    tag_q <= tag_a[k];
                end
            end

            assign val_a[k+1] = val_q;
            assign vld_a[k+1] = vld_q;
            assign idx_a[k+1] = idx_q;
            assign tag_a[k+1] = tag_q;
        end else begin : g_pass
            assign val_a[k+1] = val_c;
            assign vld_a[k+1] = vld_a[k];
            assign idx_a[k+1] = idx_a[k];
            assign tag_a[k+1] = tag_a[k];
        end
    end

    logic [W_R-1:0] r;
    logic [W_Q-1:0] q_sel;
    logic           legal;
    logic [W_R:0]   d2;
    logic [W_R:0]   d1;
    logic [W_Q-1:0] red_c;

    assign r     = W_R'(val_a[STEPS]);
    assign legal = (32'(idx_a[STEPS]) < NUM_MOD);

    always_comb begin
        q_sel = '0;
        for (int unsigned m = 0; m < NUM_MOD; m++) begin
            if (idx_a[STEPS] == IDX_W'(m)) q_sel = MODULI[m*W_Q +: W_Q];
        end
    end

    // r < 3q: try r-2q and r-q in parallel, keep the first non-negative one.
    assign d2    = {1'b0, r} - {1'b0, q_sel, 1'b0};
    assign d1    = {1'b0, r} - {2'b00, q_sel};
    assign red_c = !d2[W_R] ? W_Q'(d2) : (!d1[W_R] ? W_Q'(d1) : W_Q'(r));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (advance) begin
            out_valid <= vld_a[STEPS];
            if (vld_a[STEPS]) begin
                out_data <= legal ? red_c : '0;
                out_tag  <= tag_a[STEPS];
                out_err  <= !legal;
            end
        end
    end

endmodule

// File: tb/tb_windowed_reduction_pipe.sv
// Scoreboard bench for windowed_reduction_pipe against a plain x % q reference.
module tb_windowed_reduction_pipe;

    localparam int unsigned W_IN    = 60;
    localparam int unsigned W_Q     = 30;
    localparam int unsigned W_TAG   = 8;
    localparam int unsigned NUM_MOD = 6;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned LAT     = 4;
    localparam longint unsigned MODS [NUM_MOD] = '{
        64'd1068564481, 64'd1069219841, 64'd1070727169,
        64'd1071513601, 64'd1072496641, 64'd1073479681
    };
    localparam longint unsigned Q0 = 64'd1068564481;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W_IN-1:0]  in_data;
    logic [IDX_W-1:0] in_mod_idx;
    logic [W_TAG-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W_Q-1:0]   out_data;
    logic [W_TAG-1:0] out_tag;
    logic             out_err;

    windowed_reduction_pipe #(
        .W_IN(W_IN), .W_Q(W_Q), .WINDOW(6), .NUM_MOD(NUM_MOD), .REG_EVERY(2), .W_TAG(W_TAG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mod_idx(in_mod_idx), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W_Q-1:0]   data;
        logic [W_TAG-1:0] tag;
        logic             err;
        logic             lat_chk;
        int unsigned      cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;
    int unsigned n_out  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W_IN-1:0] x, input logic [IDX_W-1:0] idx,
                                   input logic [W_TAG-1:0] tag);
        exp_t e;
        e.tag = tag;
        e.lat_chk = 1'b0;
        e.cyc = 0;
        if (int'(idx) < int'(NUM_MOD)) begin
            e.data = W_Q'(64'(x) % MODS[idx]);
            e.err  = 1'b0;
        end else begin
            e.data = '0;
            e.err  = 1'b1;
        end
        return e;
    endfunction

    // Output monitor: pops the scoreboard on every output transfer, also watches stall stability.
    logic             stall_prev = 1'b0;
    logic [W_Q-1:0]   data_prev;
    logic [W_TAG-1:0] tag_prev;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(data_prev));
                check("stall_tag", 64'(out_tag), 64'(tag_prev));
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
            tag_prev   = out_tag;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %0d tag %0d, none expected",
                             out_data, out_tag);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_tag", 64'(out_tag), 64'(e.tag));
                    check("out_err", 64'(out_err), 64'(e.err));
                    if (e.lat_chk) check("latency", 64'(cyc - e.cyc), 64'(LAT));
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Presents one sample until it is accepted; the expectation is queued at the accepting edge.
    task automatic send(input logic [W_IN-1:0] x, input logic [IDX_W-1:0] idx,
                        input logic [W_TAG-1:0] tag, input logic lat_chk);
        exp_t e;
        in_valid   = 1'b1;
        in_data    = x;
        in_mod_idx = idx;
        in_tag     = tag;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e = model(x, idx, tag);
                e.lat_chk = lat_chk;
                e.cyc = cyc;
                sb.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for tag %0d", tag);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding, required 0", sb.size());
        end
        idle(3);
    endtask

    function automatic logic [W_IN-1:0] rand_x();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return W_IN'(w);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        int unsigned n0;
        logic        done;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_mod_idx = '0;
        in_tag     = '0;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed values against q0, each with the exact latency.
        send(W_IN'(3 * Q0 + 5), 3'd0, 8'd1, 1'b1);
        send(W_IN'(Q0), 3'd0, 8'd2, 1'b1);
        send(W_IN'(2 * Q0 - 1), 3'd0, 8'd3, 1'b1);
        send(W_IN'(0), 3'd0, 8'd4, 1'b1);
        drain();

        // Largest inputs under every modulus.
        for (int i = 0; i < int'(NUM_MOD); i++) begin
            send({W_IN{1'b1}}, IDX_W'(i), 8'(16 + 2 * i), 1'b1);
            send(W_IN'((Q0 - 1) * (Q0 - 1)), IDX_W'(i), 8'(17 + 2 * i), 1'b1);
        end
        drain();

        // Illegal index followed by a legal one.
        send(rand_x(), 3'd7, 8'hA5, 1'b1);
        send(rand_x(), 3'd0, 8'h5A, 1'b1);
        drain();

        // Back-to-back stream: one acceptance per cycle.
        n0 = n_out;
        c0 = cyc;
        for (int i = 0; i < 10000; i++) begin
            send(rand_x(), IDX_W'($urandom_range(0, NUM_MOD - 1)), 8'(i), 1'b0);
        end
        check("stream_cycles", 64'(cyc - c0), 64'd10000);
        drain();
        check("stream_count", 64'(n_out - n0), 64'd10000);

        // Five-cycle backpressure window inside a 16-sample stream.
        n0 = n_out;
        fork
            for (int i = 0; i < 16; i++) send(rand_x(), IDX_W'(i % NUM_MOD), 8'(8'hC0 + i), 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(n_out - n0), 64'd16);

        // Random gaps, random backpressure, legal and illegal indices.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    send(rand_x(), IDX_W'($urandom_range(0, 7)), 8'(i), 1'b0);
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                end
                drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = (done || $urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(2);

        // Reset with three samples in flight; nothing stale may emerge.
        send(rand_x(), 3'd1, 8'h11, 1'b0);
        send(rand_x(), 3'd2, 8'h22, 1'b0);
        send(rand_x(), 3'd3, 8'h33, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        idle(6);
        send(W_IN'(3 * Q0 + 5), 3'd0, 8'h77, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/windowed_reduction_pipe.md
# windowed_reduction_pipe

Parametrised, runtime-multi-modulus windowed modular reduction pipeline. It reduces a wide product (typically the 2·W_Q-bit output of the coefficient multiplier) modulo one of NUM_MOD word-size primes, selected per sample. It adds a valid/ready handshake with backpressure, a sideband tag, and an illegal-index flag. It sits between the modular multiplier and the NTT butterfly/adder stage in the RNS datapath.

## Interface
- W_IN, 60: input operand width.
- W_Q, 30: modulus width. Every modulus satisfies 2^(W_Q-1) < q < 2^W_Q.
- WINDOW, 6: window size in bits per table lookup. Must be ≥ 2.
- NUM_MOD, 6: number of moduli selectable at run time.
- MODULI, packed NUM_MOD×W_Q: modulus list; entry i is at bits [i·W_Q +: W_Q].
- REG_EVERY, 2: insert a pipeline register after every REG_EVERY lookup steps.
- W_TAG, 8: sideband tag width.
- clk, in, 1: clock. All logic is on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: block accepts the sample this cycle.
- in_data, in, W_IN: operand x.
- in_mod_idx, in, max(1,$clog2(NUM_MOD)): modulus select.
- in_tag, in, W_TAG: passed through unchanged.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts.
- out_data, out, W_Q: x mod MODULI[idx].
- out_tag, out, W_TAG: tag aligned with out_data.
- out_err, out, 1: in_mod_idx ≥ NUM_MOD for this sample.

## Operation
- Table for modulus q, entry v (0 ≤ v < 2^WINDOW): T_q[v] = (v·2^W_Q) mod q. Entries are computed at elaboration.
- Step k (current width w > W_Q + WINDOW − 1):
  - v = bits [w−1 : w−WINDOW], s = w − WINDOW − W_Q.
  - new value = low (w−WINDOW) bits + (T_q[v] << s).
  - Result width is w−WINDOW+1.
- Final step: the remaining high bits above W_Q (fewer than WINDOW, zero-extended) index T_q. Add the table output to the low W_Q bits. The result r is < 2^W_Q + q < 3q and is W_Q+1 bits wide.
- Correction: compute r−2q and r−q in parallel. Select r−2q if it is non-negative, else r−q if non-negative, else r. The result is always < q.
- STEPS = ceil((W_IN − W_Q)/(WINDOW − 1)). Defaults give 6.
- If W_IN ≤ W_Q, the input passes directly to correction. It still goes through the output register.
- mod_idx and tag travel with the data through every register.
- If the index is illegal, the sample still flows through the pipeline. Output is out_data = 0, out_err = 1.
- Handshake:
  - The whole pipeline stalls when out_valid && !out_ready.
  - in_ready = !(out_valid && !out_ready).
  - Transfer occurs on in_valid && in_ready, and likewise on out_valid && out_ready.
  - Bubbles are not collapsed.
- Each stage holds a valid bit. Data registers may skip reset, but valid bits and outputs must reset.

## Timing
- LATENCY = ceil(STEPS/REG_EVERY) + 1 cycles without stall. Defaults give 4.
- Throughput: one sample per cycle when out_ready is held high.
- Reset (rst_n = 0 at an edge):
  - All stage valids clear; out_valid = 0, out_data = 0, out_tag = 0, out_err = 0.
  - in_ready = 1 in the cycle after reset.
  - Samples in flight are dropped.
- Stall: all stage registers hold their value and the outputs stay stable. A sample presented while in_ready = 0 is not consumed.
- Simultaneous out_ready rise and new input: both transfers occur in the same cycle.
- The combinational path from out_ready to in_ready is permitted and documented.

## Structure
- Package reduction_pkg contains:
  - function table_entry(q, v, W_Q) returning (v·2^W_Q) mod q, computed by loop doubling with conditional subtract;
  - functions calc_steps() and calc_latency();
  - the default moduli localparam.
- Sub-module window_reduction_table:
  - holds NUM_MOD ROMs of 2^WINDOW×W_Q entries, built from the package function;
  - output is muxed by the index;
  - instantiated once per step in a generate loop.
- The pipeline and correction logic stay in the top module.

## Test plan
All scenarios use q0 = 1068564481 (idx 0) unless noted.
- Basic values: in_data = 3·q0+5 → out_data 5. in_data = q0 → 0. in_data = 2·q0−1 → q0−1. in_data = 0 → 0. All emerge after exactly 4 cycles.
- Maximum input: in_data = 2^60−1 and (q0−1)², each under all 6 indices → matches the golden model `x % MODULI[i]`. This is also the worst case for the correction stage (3q bound).
- Streaming: 10,000 random back-to-back samples with random legal indices and incrementing tags → every result and tag matches, in order, one per cycle.
- Backpressure: hold out_ready low for 5 cycles during a 16-sample stream → in_ready drops in the same cycle, no sample is lost or duplicated, and out_data stays stable while stalled.
- Illegal index: in_mod_idx = 7 with NUM_MOD = 6, tag 0xA5 → out_err = 1, out_data = 0, out_tag = 0xA5. The next legal sample produces out_err = 0.
- Reset mid-stream: assert rst_n = 0 for 1 cycle with 3 samples in flight → out_valid = 0 next cycle and no stale result appears. A new sample then yields a correct result after 4 cycles.
